// File: rtl/dram_io_pkg.sv
// rtl/dram_io_pkg.sv - shared state encoding and sizing constants for the DRAM stream loader
package dram_io_pkg;

    localparam int DEF_ADDR_WIDTH = 24;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LEN_WIDTH  = 7;
    localparam int MEM_DEPTH      = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RD_ADDR = 3'd2,
        RD_OUT  = 3'd3,
        DONE    = 3'd4
    } xfer_state_t;

endpackage

// File: rtl/dram_xfer_counter.sv
// rtl/dram_xfer_counter.sv - loadable address/remaining-count pair stepped once per transferred byte
module dram_xfer_counter #(
    parameter int ADDR_WIDTH = 24,
    parameter int LEN_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [LEN_WIDTH-1:0]  count,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;

    // The address wraps naturally at full width; the DRAM only decodes the low bits.
    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        if (load) begin
            addr_d  = base;
            count_d = len;
        end else if (step) begin
            addr_d  = addr_q + ADDR_ONE;
            count_d = count_q - LEN_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    assign addr  = addr_q;
    assign count = count_q;
    assign last  = (count_q == LEN_ONE);

endmodule

// File: rtl/dram_stream_loader.sv
// rtl/dram_stream_loader.sv - moves a byte stream into DRAM (LOAD) or DRAM out to a byte stream (DUMP)
module dram_stream_loader
    import dram_io_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_load,
    input  logic                  start_dump,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  busy,
    output logic                  done
);

    xfer_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;

    logic                  cnt_load;
    logic                  cnt_step;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  count;
    logic                  last;

    dram_xfer_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .load  (cnt_load),
        .base  (base_addr),
        .len   (length),
        .step  (cnt_step),
        .addr  (addr),
        .count (count),
        .last  (last)
    );

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        cnt_load    = 1'b0;
        cnt_step    = 1'b0;
        in_ready    = 1'b0;
        mem_write   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_load || start_dump) begin
                    cnt_load = 1'b1;
                    if (length == '0) begin
                        state_d = DONE;
                    end else if (start_load) begin
                        state_d = LOAD;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            LOAD: begin
                // Write strobe follows in_valid directly so the DRAM commits on the handshake edge.
                in_ready  = 1'b1;
                mem_write = in_valid;
                if (in_valid) begin
                    cnt_step = 1'b1;
                    if (last) begin
                        state_d = DONE;
                    end
                end
            end
            RD_ADDR: begin
                out_data_d  = mem_data_out;
                out_valid_d = 1'b1;
                state_d     = RD_OUT;
            end
            RD_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_step    = 1'b1;
                    state_d     = last ? DONE : RD_ADDR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign mem_addr    = addr;
    assign mem_data_in = in_data;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);

    logic unused_count;
    assign unused_count = ^count;

endmodule

// File: tb/tb_dram_stream_loader.sv
// tb/tb_dram_stream_loader.sv - scoreboard bench for dram_stream_loader with a 64x8 DRAM model
module tb_dram_stream_loader;
    import dram_io_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_load, start_dump;
    logic [23:0] base_addr;
    logic [6:0]  length;
    logic [7:0]  in_data;
    logic        in_valid, in_ready;
    logic [7:0]  out_data;
    logic        out_valid, out_ready;
    logic        mem_write;
    logic [7:0]  mem_data_in, mem_data_out;
    logic [23:0] mem_addr;
    logic        busy, done;
    logic        mem_init;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [23:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_out[$];
    logic [7:0] mem [0:MEM_DEPTH-1];

    always #5 clk = ~clk;

    dram_stream_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start_load   (start_load),
        .start_dump   (start_dump),
        .base_addr    (base_addr),
        .length       (length),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .mem_write    (mem_write),
        .mem_data_in  (mem_data_in),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .busy         (busy),
        .done         (done)
    );

    assign mem_data_out = mem[mem_addr[5:0]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 8'h00;
            mem[0] <= 8'h7B;
            mem[1] <= 8'h59;
            mem[2] <= 8'h43;
            mem[6] <= 8'h78;
            mem[7] <= 8'h86;
        end else if (mem_write) begin
            mem[mem_addr[5:0]] <= mem_data_in;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every DRAM write and every valid output byte is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset && !mem_init) begin
            if (mem_write) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected_addr", {8'h0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    check("wr_addr", {8'h0, mem_addr}, {8'h0, exp_wr[0].a});
                    check("wr_data", {24'h0, mem_data_in}, {24'h0, exp_wr[0].d});
                    void'(exp_wr.pop_front());
                end
            end
            if (out_valid) begin
                if (exp_out.size() == 0) begin
                    check("out_unexpected", {24'h0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    check("out_data", {24'h0, out_data}, {24'h0, exp_out[0]});
                    if (out_ready) void'(exp_out.pop_front());
                end
            end
        end
    end

    task automatic do_load(input logic [23:0] base, input logic [6:0] len, input logic [31:0] data,
                           input logic [7:0] pat, input int plen, input bit both);
        int idx;
        int p;
        logic v;
        logic [23:0] a;
        @(posedge clk); #1;
        start_load = 1'b1; start_dump = both; base_addr = base; length = len;
        @(posedge clk); #1;
        start_load = 1'b0; start_dump = 1'b0;
        idx = 0; p = 0;
        while (idx < int'(len) && p < 64) begin
            v = pat[p % plen];
            in_valid = v;
            in_data = data[8*idx +: 8];
            a = base + 24'(idx);
            if (v) exp_wr.push_back('{a: a, d: data[8*idx +: 8]});
            @(posedge clk); #1;
            if (v) idx++;
            p++;
        end
        in_valid = 1'b0;
        check("load_done_pulse", {31'h0, done}, 32'h1);
        @(posedge clk); #1;
        check("load_done_one_cycle", {31'h0, done}, 32'h0);
        check("load_idle_busy", {31'h0, busy}, 32'h0);
    endtask

    task automatic do_dump(input logic [23:0] base, input logic [6:0] len, input logic [31:0] data,
                           input int stall, input int exp_cycles);
        int n;
        int sc;
        for (int i = 0; i < int'(len); i++) exp_out.push_back(data[8*i +: 8]);
        out_ready = (stall == 0);
        @(posedge clk); #1;
        start_dump = 1'b1; base_addr = base; length = len;
        @(posedge clk); #1;
        start_dump = 1'b0;
        n = 0; sc = 0;
        while (!done && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (!out_ready && out_valid) begin
                check("stall_addr_hold", {8'h0, mem_addr}, {8'h0, base});
                sc++;
                if (sc == stall) out_ready = 1'b1;
            end
        end
        check("dump_done", {31'h0, done}, 32'h1);
        check("dump_cycles", n, exp_cycles);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("dump_done_one_cycle", {31'h0, done}, 32'h0);
    endtask

    initial begin
        reset = 1'b1; mem_init = 1'b1;
        start_load = 1'b0; start_dump = 1'b0;
        base_addr = '0; length = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_data", {24'h0, out_data}, 32'h0);
        check("rst_mem_write", {31'h0, mem_write}, 32'h0);
        check("rst_in_ready", {31'h0, in_ready}, 32'h0);
        check("rst_mem_addr", {8'h0, mem_addr}, 32'h0);
        mem_init = 1'b0;
        reset = 1'b0;

        do_dump(24'h000000, 7'd3, 32'h0043_597B, 0, 6);
        do_dump(24'h000006, 7'd2, 32'h0000_8678, 5, 8);

        do_load(24'h000010, 7'd4, 32'hDDCC_BBAA, 8'hFF, 1, 1'b0);
        check("mem16", {24'h0, mem[16]}, 32'hAA);
        check("mem17", {24'h0, mem[17]}, 32'hBB);
        check("mem18", {24'h0, mem[18]}, 32'hCC);
        check("mem19", {24'h0, mem[19]}, 32'hDD);

        do_load(24'h000018, 7'd3, 32'h0033_2211, 8'h29, 6, 1'b0);
        check("gap_mem24", {24'h0, mem[24]}, 32'h11);
        check("gap_mem26", {24'h0, mem[26]}, 32'h33);

        @(posedge clk); #1;
        start_load = 1'b1; start_dump = 1'b1; base_addr = 24'h000005; length = 7'd0;
        @(posedge clk); #1;
        start_load = 1'b0; start_dump = 1'b0;
        check("len0_done", {31'h0, done}, 32'h1);
        @(posedge clk); #1;
        check("len0_idle", {31'h0, busy}, 32'h0);
        check("len0_no_out", {31'h0, out_valid}, 32'h0);

        do_load(24'h000020, 7'd1, 32'h0000_005A, 8'hFF, 1, 1'b1);
        check("both_mem32", {24'h0, mem[32]}, 32'h5A);
        check("both_no_out", exp_out.size(), 0);

        do_load(24'hFFFFFF, 7'd2, 32'h0000_2211, 8'hFF, 1, 1'b0);
        check("wrap_mem63", {24'h0, mem[63]}, 32'h11);
        check("wrap_mem0", {24'h0, mem[0]}, 32'h22);

        @(posedge clk); #1;
        start_load = 1'b1; base_addr = 24'h000028; length = 7'd4;
        @(posedge clk); #1;
        start_load = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data = 8'hC0 + 8'(k);
            exp_wr.push_back('{a: 24'h000028 + 24'(k), d: 8'hC0 + 8'(k)});
            @(posedge clk); #1;
        end
        in_data = 8'hC2;
        #1 reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_mem_write", {31'h0, mem_write}, 32'h0);
        check("mid_rst_in_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; in_valid = 1'b0;
        check("rst_mem40", {24'h0, mem[40]}, 32'hC0);
        check("rst_mem41", {24'h0, mem[41]}, 32'hC1);
        check("rst_mem42", {24'h0, mem[42]}, 32'h00);
        check("rst_mem43", {24'h0, mem[43]}, 32'h00);

        do_load(24'h000030, 7'd2, 32'h0000_E1E0, 8'hFF, 1, 1'b0);
        check("after_rst_mem48", {24'h0, mem[48]}, 32'hE0);
        check("after_rst_mem49", {24'h0, mem[49]}, 32'hE1);

        repeat (2) @(posedge clk);
        #1;
        check("wr_queue_empty", exp_wr.size(), 0);
        check("out_queue_empty", exp_out.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dram_stream_loader.md
Name: dram_stream_loader

Overview:
- Transfer engine sitting directly in front of the 64x8 data DRAM; it is the only other agent on the DRAM port when I/O is active.
- LOAD mode: accepts a valid/ready byte stream (e.g. from the UART receiver) and writes it to consecutive DRAM addresses.
- DUMP mode: reads consecutive DRAM addresses and presents them as a valid/ready byte stream (e.g. to the UART transmitter).
- Drives the DRAM's write, data_in and data_addr, and consumes the DRAM's combinational data_out.

Parameters:
- ADDR_WIDTH, 24, DRAM address width.
- DATA_WIDTH, 8, byte width.
- LEN_WIDTH, 7, transfer length width; supports 0..64 bytes.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_load  in  1  begin LOAD; sampled only in IDLE.
- start_dump  in  1  begin DUMP; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first DRAM address; captured at start.
- length  in  LEN_WIDTH  byte count; captured at start.
- in_data  in  DATA_WIDTH  LOAD stream data.
- in_valid  in  1  LOAD stream valid.
- in_ready  out  1  LOAD stream ready.
- out_data  out  DATA_WIDTH  DUMP stream data, registered.
- out_valid  out  1  DUMP stream valid.
- out_ready  in  1  DUMP stream ready.
- mem_write  out  1  to DRAM write.
- mem_data_in  out  DATA_WIDTH  to DRAM data_in.
- mem_addr  out  ADDR_WIDTH  to DRAM data_addr.
- mem_data_out  in  DATA_WIDTH  from DRAM data_out (combinational read).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a transfer completes.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-high.
- Reset values: state=IDLE, addr=0, count=0, out_data=0, out_valid=0, done=0. Combinational outputs in IDLE: in_ready=0, mem_write=0, busy=0.
- Reset mid-transfer: immediately returns to IDLE. mem_write and out_valid drop asynchronously. Bytes already written stay in DRAM.
- States: IDLE, LOAD, RD_ADDR, RD_OUT, DONE.
- IDLE:
  - start_load wins if both starts are high; start_dump is then ignored.
  - On either start: addr<=base_addr, count<=length.
  - If length==0: go to DONE with no DRAM access.
  - Otherwise: start_load -> LOAD; start_dump -> RD_ADDR.
- LOAD:
  - in_ready=1.
  - mem_addr=addr, mem_data_in=in_data, mem_write=in_valid (combinational, same cycle as the handshake); the DRAM commits the byte on that rising edge.
  - On handshake: addr<=addr+1, count<=count-1. If count==1, go to DONE.
  - No write and no state change on cycles where in_valid=0.
- RD_ADDR:
  - mem_addr=addr, mem_write=0.
  - At the clock edge: out_data<=mem_data_out, out_valid<=1, go to RD_OUT.
- RD_OUT:
  - out_valid=1 and out_data are held stable until out_ready=1.
  - On handshake: out_valid<=0, addr<=addr+1, count<=count-1. If count==1, go to DONE; else go to RD_ADDR.
  - Throughput: one byte per 2 cycles when out_ready stays high.
- DONE: done=1 for exactly one cycle, then IDLE. Starts are ignored in DONE.
- Starts asserted while busy=1 are ignored; no queuing.
- Address arithmetic:
  - addr is a full ADDR_WIDTH-bit counter wrapping 0xFFFFFF->0x000000.
  - The DRAM decodes only addr[5:0], so transfers past 63 alias to the low locations; this is intended.
- mem_data_in=in_data in all states; it is only qualified by mem_write.

Decomposition:
- Shared package dram_io_pkg holds:
  - the state encoding constants (IDLE=0, LOAD=1, RD_ADDR=2, RD_OUT=3, DONE=4, 3 bits);
  - ADDR_WIDTH/DATA_WIDTH/LEN_WIDTH defaults;
  - MEM_DEPTH=64.
- One natural sub-module, dram_xfer_counter: loadable addr and count registers with an increment/decrement strobe and a last flag (count==1).

Test Plan:
1. Load 4 bytes: start_load, base 0x000010, length 4; stream 0xAA,0xBB,0xCC,0xDD with in_valid continuously high -> mem_write high 4 consecutive cycles at mem_addr 0x10..0x13; done pulses the following cycle; DRAM[16..19]=AA,BB,CC,DD.
2. Dump from initialised DRAM: base 0, length 3, out_ready=1 -> out_data 0x7B,0x59,0x43 in order, one byte per 2 cycles; done after the third handshake; mem_write stays 0 throughout.
3. Backpressure: dump base 6, length 2, out_ready low for 5 cycles on the first byte -> out_valid held high with out_data=0x78 stable; mem_addr does not advance until the handshake; second byte=0x86.
4. Gapped load: length 3 with in_valid toggling 1,0,0,1,0,1 -> exactly 3 writes, only on the in_valid=1 cycles, at consecutive addresses.
5. Edge cases:
   - start_load and start_dump together with length 0 -> LOAD chosen, no write, done the next cycle.
   - base 0xFFFFFF, length 2 load -> writes at 0xFFFFFF then 0x000000.
6. Reset mid-load: length 4, assert reset after 2 accepted bytes -> busy, mem_write and in_ready drop immediately; only the first 2 bytes are written; a new load started afterwards works from its own base_addr.
